// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Counter width; a 2-bit operand still needs one counter bit.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Ripple-carry adder, the single arithmetic element of the multiplier.
module shift_add_multiplier_adder #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             cin,
  output logic [Width-1:0] sum,
  output logic             cout
);

  // Carry ripples LSB to MSB through a local variable.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = {Width{1'b0}};
    for (int i = 0; i < Width; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Radix-2 sequential unsigned multiplier: one partial product per clock,
// valid/ready on operand and result sides.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int Width = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [Width-1:0]          a,
  input  logic [Width-1:0]          b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [prod_w(Width)-1:0]  product
);

  localparam int CNT_W = cnt_w(Width);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Width - 1);

  state_t             state_q, state_d;
  logic [Width-1:0]   mcand_q, mcand_d;
  logic [Width-1:0]   acc_hi_q, acc_hi_d;
  logic [Width-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [Width-1:0]   add_b_s;
  logic [Width-1:0]   sum_s;
  logic               cout_s;

  assign add_b_s = acc_lo_q[0] ? mcand_q : {Width{1'b0}};

  shift_add_multiplier_adder #(
    .Width(Width)
  ) u_adder (
    .a   (acc_hi_q),
    .b   (add_b_s),
    .cin (1'b0),
    .sum (sum_s),
    .cout(cout_s)
  );

  // Next-state and datapath update for the accept / run / deliver sequence.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = {Width{1'b0}};
          count_d  = {CNT_W{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // The carry out becomes the new MSB, so all-ones operands stay exact.
        {acc_hi_d, acc_lo_d} = {cout_s, sum_s, acc_lo_q[Width-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and handshake flops; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= {Width{1'b0}};
      acc_hi_q    <= {Width{1'b0}};
      acc_lo_q    <= {Width{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = {acc_hi_q, acc_lo_q};

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned multiplier, radix-2 shift-and-add; one partial product per clock.
- Consumes the existing ripple-carry Adder as its only arithmetic element and registers that adder's sum and carry every cycle.
- Valid/ready on both sides so it drops into the datapath between operand issue and result writeback.
- Area-lean alternative to a combinational multiplier.

Parameters:
- Width, 32, operand width in bits; legal range 2..64. Product is 2*Width bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  Width  multiplicand, unsigned
- b  input  Width  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*Width  a*b, unsigned, exact (no truncation)

Behaviour:
- Reset (async assert, sync release by the system):
  - state=IDLE, out_valid=0, product=0, in_ready=1.
  - All internal registers (mcand, acc_hi, acc_lo, count) are cleared to 0.
- Registers:
  - mcand[Width-1:0]
  - acc_hi[Width-1:0]
  - acc_lo[Width-1:0], which holds the multiplier and is shifted out
  - count[$clog2(Width)-1:0]
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: mcand<=a, acc_lo<=b, acc_hi<=0, count<=0, go RUN.
- RUN (in_ready=0, out_valid=0):
  - Adder inputs: a=acc_hi, b=(acc_lo[0] ? mcand : 0), cin=0. The adder always runs; there is no bypass path.
  - Each edge, the Width+1-bit result {cout,sum} is shifted right one bit together with acc_lo: {acc_hi,acc_lo} <= {cout,sum,acc_lo[Width-1:1]}.
  - The adder cout must be captured. Dropping it is a bug and breaks all-ones operands.
  - count increments each edge. On the edge where count==Width-1, go DONE.
- DONE:
  - out_valid=1, product={acc_hi,acc_lo}.
  - product is held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: go IDLE and drop out_valid.
- Latency: acceptance edge E; RUN spans exactly Width edges (E+1..E+Width); out_valid is high from after edge E+Width.
- Throughput: one cycle in IDLE minimum between the output handshake and the next acceptance. There is no overlap of jobs.
- Boundary conditions:
  - a/b changes after acceptance are ignored.
  - in_valid during RUN/DONE is not accepted and does not stall or corrupt the job.
  - out_ready high before out_valid has no effect.
  - out_ready held low indefinitely: DONE is held, product is frozen.
  - Zero operand: full Width cycles are still used (fixed latency); result is 0.
  - rst_n low mid-RUN or mid-DONE: the job is aborted immediately, no out_valid, next job starts clean.
- product is registered, not combinational from the adder. in_ready and out_valid are decoded from state only.

Decomposition:
- Shared package mul_pkg:
  - state_t enum {IDLE, RUN, DONE}
  - constant CNT_W = $clog2(Width) helper
  - localparam for 2*Width product width
- One sub-module: the existing Adder, instantiated once with Width passed through.
- The FSM, shift registers and counter live in shift_add_multiplier itself.

Test Plan:
- Reset held, then released:
  - in_ready=1, out_valid=0, product=0.
  - in_valid pulse with rst_n low is not accepted.
- a=3, b=5 accepted at edge E:
  - out_valid rises after edge E+32, product=15.
  - in_ready=0 for edges E+1..E+33.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF:
  - product=64'hFFFFFFFE00000001; checks carry capture.
- a=32'h12345678, b=0, then a=0, b=32'hDEADBEEF:
  - product=0 both times, each after exactly 32 RUN cycles.
- a=1000, b=1000 with out_ready held low 10 cycles after out_valid:
  - product stays 1000000.
  - new in_valid with a=7, b=9 during the stall is not accepted.
  - After the handshake, the 7*9 job is accepted in IDLE and yields 63.
- rst_n asserted at RUN cycle 17 of a=7, b=9:
  - outputs return to reset values asynchronously.
  - A subsequent a=6, b=4 job yields 24.
  - Random 2000 operand pairs at Width=32 and Width=8 match a reference model.
